// File: rtl/phy_regread_stage_pkg.sv
// Shared core package: decoded control bundle, ALU/memory op enums, the NOP
// control word, and default datapath widths for the register-read stage.
package phy_regread_stage_pkg;

  localparam int REG_VAL_WIDTH     = 32;
  localparam int PHY_REG_NUM       = 64;
  localparam int PHY_REG_NUM_WIDTH = $clog2(PHY_REG_NUM);
  localparam int INST_ADDR_WIDTH   = 32;

  typedef enum logic {
    src_reg2 = 1'b0,
    src_imm  = 1'b1
  } alu_src_t;

  typedef enum logic [2:0] {
    add_op, sub_op, and_op, or_op, xor_op, sll_op, srl_op, slt_op
  } alu_op_t;

  typedef enum logic [1:0] {
    no_mem_op, load_op, store_op
  } mem_op_t;

  typedef struct packed {
    alu_src_t alu_src;
    alu_op_t  alu_op;
    logic     is_branch_op;
    mem_op_t  memory_op;
    logic     reg_wb;
  } control_t;

  localparam control_t NOP_CONTROL = '{
    alu_src:      src_reg2,
    alu_op:       add_op,
    is_branch_op: 1'b0,
    memory_op:    no_mem_op,
    reg_wb:       1'b0
  };

endpackage

// File: rtl/phy_regread_stage_regfile.sv
// Multi-port physical register file.
// Ports:
//   clk, reset          clock, async active-high reset (clears all entries)
//   rd_reg / rd_val     NUM_RD combinational read ports with write-through bypass
//   wr_en/wr_reg/wr_val NUM_WR write ports, committed at posedge
// p0 is hard-wired to zero. When several write ports hit the same register
// in one cycle the highest port index wins, both in storage and on bypass.
module phy_regfile_mp #(
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2,
  parameter int NREGS  = 64,
  parameter int IDX_W  = 6,
  parameter int VAL_W  = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_RD-1:0][IDX_W-1:0]   rd_reg,
  output logic [NUM_RD-1:0][VAL_W-1:0]   rd_val,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][IDX_W-1:0]   wr_reg,
  input  logic [NUM_WR-1:0][VAL_W-1:0]   wr_val
);

  logic [VAL_W-1:0] r_regs [NREGS];

  // Later loop iterations override earlier ones, giving the higher port priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_reg[k] != '0)) r_regs[wr_reg[k]] <= wr_val[k];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_val[p] = r_regs[rd_reg[p]];
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_reg[k] == rd_reg[p])) rd_val[p] = wr_val[k];
      end
      if (rd_reg[p] == '0) rd_val[p] = '0;
    end
  end

endmodule

// File: rtl/phy_regread_stage.sv
// Register-read pipeline stage between rename/dispatch and execute.
// Reads two operands per lane from the physical register file (with same-cycle
// commit bypass) and registers them with the lane sideband into a valid/ready
// output stage supporting stall, flush-to-NOP and refresh of held operands.
// Ports:
//   clk, reset                 clock, async active-high reset
//   flush                      squash held group and the incoming group
//   in_valid/in_ready          upstream handshake for one lane group
//   lane_en, src*/dst_reg,
//   control_in, pc_in, imm_in  per-lane incoming fields
//   wb_en/wb_reg/wb_val        commit write ports
//   out_valid/out_ready        downstream handshake
//   *_out, src1_val, src2_val  registered group presented to execute
module phy_regread_stage #(
  parameter int NUM_LANES         = 2,
  parameter int NUM_WB_PORTS      = 2,
  parameter int PHY_REG_NUM       = phy_regread_stage_pkg::PHY_REG_NUM,
  parameter int PHY_REG_NUM_WIDTH = $clog2(PHY_REG_NUM),
  parameter int REG_VAL_WIDTH     = phy_regread_stage_pkg::REG_VAL_WIDTH,
  parameter int INST_ADDR_WIDTH   = phy_regread_stage_pkg::INST_ADDR_WIDTH,
  parameter int IMM_WIDTH         = REG_VAL_WIDTH
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               flush,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [NUM_LANES-1:0]                               lane_en,
  input  logic [NUM_LANES-1:0][PHY_REG_NUM_WIDTH-1:0]        src1_reg,
  input  logic [NUM_LANES-1:0][PHY_REG_NUM_WIDTH-1:0]        src2_reg,
  input  logic [NUM_LANES-1:0][PHY_REG_NUM_WIDTH-1:0]        dst_reg,
  input  phy_regread_stage_pkg::control_t [NUM_LANES-1:0]    control_in,
  input  logic [NUM_LANES-1:0][INST_ADDR_WIDTH-1:0]          pc_in,
  input  logic [NUM_LANES-1:0][IMM_WIDTH-1:0]                imm_in,
  input  logic [NUM_WB_PORTS-1:0]                            wb_en,
  input  logic [NUM_WB_PORTS-1:0][PHY_REG_NUM_WIDTH-1:0]     wb_reg,
  input  logic [NUM_WB_PORTS-1:0][REG_VAL_WIDTH-1:0]         wb_val,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [NUM_LANES-1:0]                               lane_en_out,
  output logic [NUM_LANES-1:0][REG_VAL_WIDTH-1:0]            src1_val,
  output logic [NUM_LANES-1:0][REG_VAL_WIDTH-1:0]            src2_val,
  output logic [NUM_LANES-1:0][PHY_REG_NUM_WIDTH-1:0]        src1_reg_out,
  output logic [NUM_LANES-1:0][PHY_REG_NUM_WIDTH-1:0]        src2_reg_out,
  output logic [NUM_LANES-1:0][PHY_REG_NUM_WIDTH-1:0]        dst_reg_out,
  output phy_regread_stage_pkg::control_t [NUM_LANES-1:0]    control_out,
  output logic [NUM_LANES-1:0][INST_ADDR_WIDTH-1:0]          pc_out,
  output logic [NUM_LANES-1:0][IMM_WIDTH-1:0]                imm_out
);
  import phy_regread_stage_pkg::*;

  localparam int NUM_RD = 2 * NUM_LANES;

  logic [NUM_RD-1:0][PHY_REG_NUM_WIDTH-1:0]      w_rd_reg;
  logic [NUM_RD-1:0][REG_VAL_WIDTH-1:0]          w_rd_val;
  logic [NUM_LANES-1:0][REG_VAL_WIDTH-1:0]       w_src1_fresh;
  logic [NUM_LANES-1:0][REG_VAL_WIDTH-1:0]       w_src2_fresh;
  logic                                          w_accept;

  logic                                          r_out_valid;
  logic [NUM_LANES-1:0]                          r_lane_en_out;
  logic [NUM_LANES-1:0][REG_VAL_WIDTH-1:0]       r_src1_val;
  logic [NUM_LANES-1:0][REG_VAL_WIDTH-1:0]       r_src2_val;
  logic [NUM_LANES-1:0][PHY_REG_NUM_WIDTH-1:0]   r_src1_reg_out;
  logic [NUM_LANES-1:0][PHY_REG_NUM_WIDTH-1:0]   r_src2_reg_out;
  logic [NUM_LANES-1:0][PHY_REG_NUM_WIDTH-1:0]   r_dst_reg_out;
  control_t [NUM_LANES-1:0]                      r_control_out;
  logic [NUM_LANES-1:0][INST_ADDR_WIDTH-1:0]     r_pc_out;
  logic [NUM_LANES-1:0][IMM_WIDTH-1:0]           r_imm_out;

  // Read ports 0..NUM_LANES-1 serve src1, the upper half serves src2.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      w_rd_reg[l]             = src1_reg[l];
      w_rd_reg[NUM_LANES + l] = src2_reg[l];
    end
  end

  phy_regfile_mp #(
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WB_PORTS),
    .NREGS  (PHY_REG_NUM),
    .IDX_W  (PHY_REG_NUM_WIDTH),
    .VAL_W  (REG_VAL_WIDTH)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .rd_reg (w_rd_reg),
    .rd_val (w_rd_val),
    .wr_en  (wb_en),
    .wr_reg (wb_reg),
    .wr_val (wb_val)
  );

  // Held operands pick up commits to their source register while stalled;
  // the producer may complete after the group reached this stage.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      w_src1_fresh[l] = r_src1_val[l];
      w_src2_fresh[l] = r_src2_val[l];
      for (int k = 0; k < NUM_WB_PORTS; k++) begin
        if (wb_en[k] && (r_src1_reg_out[l] != '0) && (wb_reg[k] == r_src1_reg_out[l]))
          w_src1_fresh[l] = wb_val[k];
        if (wb_en[k] && (r_src2_reg_out[l] != '0) && (wb_reg[k] == r_src2_reg_out[l]))
          w_src2_fresh[l] = wb_val[k];
      end
    end
  end

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid    <= 1'b0;
      r_lane_en_out  <= '0;
      r_src1_val     <= '0;
      r_src2_val     <= '0;
      r_src1_reg_out <= '0;
      r_src2_reg_out <= '0;
      r_dst_reg_out  <= '0;
      r_pc_out       <= '0;
      r_imm_out      <= '0;
      for (int l = 0; l < NUM_LANES; l++) r_control_out[l] <= NOP_CONTROL;
    end else if (flush) begin
      r_out_valid   <= 1'b0;
      r_lane_en_out <= '0;
      for (int l = 0; l < NUM_LANES; l++) r_control_out[l] <= NOP_CONTROL;
    end else if (w_accept) begin
      r_out_valid    <= 1'b1;
      r_lane_en_out  <= lane_en;
      r_src1_reg_out <= src1_reg;
      r_src2_reg_out <= src2_reg;
      r_dst_reg_out  <= dst_reg;
      r_pc_out       <= pc_in;
      r_imm_out      <= imm_in;
      for (int l = 0; l < NUM_LANES; l++) begin
        r_src1_val[l]    <= w_rd_val[l];
        r_src2_val[l]    <= w_rd_val[NUM_LANES + l];
        r_control_out[l] <= lane_en[l] ? control_in[l] : NOP_CONTROL;
      end
    end else if (out_ready) begin
      // Group consumed with nothing behind it: present a bubble.
      r_out_valid <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) r_control_out[l] <= NOP_CONTROL;
    end else if (r_out_valid) begin
      r_src1_val <= w_src1_fresh;
      r_src2_val <= w_src2_fresh;
    end
  end

  assign out_valid    = r_out_valid;
  assign lane_en_out  = r_lane_en_out;
  assign src1_val     = r_src1_val;
  assign src2_val     = r_src2_val;
  assign src1_reg_out = r_src1_reg_out;
  assign src2_reg_out = r_src2_reg_out;
  assign dst_reg_out  = r_dst_reg_out;
  assign control_out  = r_control_out;
  assign pc_out       = r_pc_out;
  assign imm_out      = r_imm_out;

endmodule

// File: doc/phy_regread_stage.md
Name: phy_regread_stage

Overview:
- Parametrised register-read pipeline stage for the OOO core: multi-lane issue reads, multi-port commit writes.
- Holds the physical register file and reads two source operands per lane.
- Forwards same-cycle commit writes, then registers operands and sideband fields into a valid/ready output stage.
- Output stage supports stall, flush-to-NOP, and refresh of held operands while stalled. Sits between rename/dispatch and execute.

Parameters:
NUM_LANES, 2, issue lanes read per cycle
NUM_WB_PORTS, 2, commit write ports per cycle
PHY_REG_NUM, 64, number of physical registers
PHY_REG_NUM_WIDTH, $clog2(PHY_REG_NUM), physical register index width
REG_VAL_WIDTH, 32, register value width
INST_ADDR_WIDTH, 32, PC width
IMM_WIDTH, REG_VAL_WIDTH, generated immediate width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  squash stage contents and incoming group
in_valid  in  1  incoming lane group valid
in_ready  out  1  stage can accept group this cycle
lane_en  in  NUM_LANES  per-lane occupancy within group
src1_reg, src2_reg, dst_reg  in  NUM_LANES x PHY_REG_NUM_WIDTH  per-lane physical registers
control_in  in  NUM_LANES x control_t  per-lane decoded control
pc_in  in  NUM_LANES x INST_ADDR_WIDTH  per-lane PC
imm_in  in  NUM_LANES x IMM_WIDTH  per-lane immediate
wb_en  in  NUM_WB_PORTS  commit write enables
wb_reg  in  NUM_WB_PORTS x PHY_REG_NUM_WIDTH  commit destinations
wb_val  in  NUM_WB_PORTS x REG_VAL_WIDTH  commit values
out_valid  out  1  registered group valid
out_ready  in  1  execute accepts group
lane_en_out  out  NUM_LANES  registered lane occupancy
src1_val, src2_val  out  NUM_LANES x REG_VAL_WIDTH  operand values
src1_reg_out, src2_reg_out, dst_reg_out  out  NUM_LANES x PHY_REG_NUM_WIDTH  registered indices
control_out  out  NUM_LANES x control_t  registered control
pc_out  out  NUM_LANES x INST_ADDR_WIDTH  registered PC
imm_out  out  NUM_LANES x IMM_WIDTH  registered immediate

Behaviour:
- Reset: regfile all zero. out_valid=0, lane_en_out=0. All value/index/pc/imm outputs 0. Every control_out lane = NOP_CONTROL (alu_src=src_reg2, alu_op=add_op, is_branch_op=0, memory_op=no_mem_op, reg_wb=0).
- Register p0 reads 0 always; writes to p0 are ignored.
- Writes commit at posedge. Reads are combinational with write-through bypass: a read of register R in the same cycle as wb_en[k] with wb_reg[k]==R returns wb_val[k].
- Multiple ports writing the same register in one cycle: highest port index wins, for both storage and bypass.
- in_ready = !out_valid || out_ready. Group accepted on in_valid && in_ready && !flush.
- Latency: one cycle from acceptance to out_valid=1 with all fields of that group.
- Output regs load on acceptance. If out_ready && !accept, out_valid->0; control_out lanes->NOP_CONTROL; other fields keep their values.
- Stall (out_valid && !out_ready): all fields hold, except held-operand refresh. Any wb write matching a held srcN_reg_out (non-zero) updates srcN_val next cycle, same priority rule.
- Disabled lanes (lane_en=0) load control NOP_CONTROL; their operands are don't-care.
- flush (highest priority): next cycle out_valid=0, lane_en_out=0, all control_out=NOP_CONTROL. Incoming group is dropped regardless of in_ready.
- flush never blocks regfile writes; commits in a flush cycle still land.
- Reset mid-stall or mid-flush: returns to the reset state immediately (async).

Decomposition:
- Shared package (existing core package): control_t, alu/mem enums, NOP_CONTROL, REG_VAL_WIDTH, PHY_REG_NUM_WIDTH, INST_ADDR_WIDTH.
- Sub-module phy_regfile_mp holds storage with 2*NUM_LANES read ports, NUM_WB_PORTS write ports, bypass, p0 rule and priority.
- The stage instantiates phy_regfile_mp once, plus the output pipeline register and refresh logic.

Test Plan:
- Reset then idle -> out_valid=0, all control_out==NOP_CONTROL, regfile reads 0 for p1..p63.
- Commit wb0 p5=0xDEAD_BEEF in cycle N; lane0 reads src1=p5 in cycle N -> src1_val[0]=0xDEADBEEF at N+1 (bypass). Repeat at N+2 -> same value from storage.
- Same cycle wb0 p7=0x1111, wb1 p7=0x2222 -> later read of p7 returns 0x2222. wb to p0=0xFFFF -> p0 reads 0.
- Accept group (lane0 src1=p9), hold out_ready=0 three cycles, commit p9=0x55 during stall -> src1_val[0]=0x55 next cycle. in_ready=0 throughout; pc_out/imm_out unchanged.
- Group valid at output; flush=1 with in_valid=1 -> next cycle out_valid=0, control_out NOP, incoming group not seen. A same-cycle wb p3=0x77 still reads back 0x77.
- Back-to-back groups with out_ready=1, NUM_LANES=2, lane_en=2'b01 -> one group per cycle, lane1 control_out=NOP_CONTROL, no bubbles.
